// File: rtl/ray_sequencer_if.sv
// ray_seq_if: handshake and status bundle between the ray-cast sequencer and
// its datapath/downstream neighbours.
//   slave  modport (sequencer side): takes start/abort, the datapath
//          completion flags, ray distance/hit and the downstream ack;
//          drives the phase strobes, column/step indices and frame status.
//   master modport (datapath / test side): the mirror image.
interface ray_seq_if #(
  parameter int COL_W  = 10,
  parameter int STEP_W = 7,
  parameter int DIST_W = 10
);
  logic              start;
  logic              abort;
  logic              mult_done;
  logic [DIST_W-1:0] distwall;
  logic              hitwall;
  logic              ceil_done;
  logic              col_ack;

  logic              init;
  logic              mult;
  logic              loop;
  logic              ceil_calc;
  logic [COL_W-1:0]  col_idx;
  logic [STEP_W-1:0] step_cnt;
  logic              col_valid;
  logic              col_timeout;
  logic              busy;
  logic              frame_done;

  modport slave (
    input  start, abort, mult_done, distwall, hitwall, ceil_done, col_ack,
    output init, mult, loop, ceil_calc, col_idx, step_cnt,
           col_valid, col_timeout, busy, frame_done
  );

  modport master (
    output start, abort, mult_done, distwall, hitwall, ceil_done, col_ack,
    input  init, mult, loop, ceil_calc, col_idx, step_cnt,
           col_valid, col_timeout, busy, frame_done
  );
endinterface

// File: rtl/ray_sequencer.sv
// ray_sequencer: per-frame control FSM for a column ray caster. For every
// column it runs INIT -> (MULT -> LOOP)* -> CEIL -> EMIT, stepping a ray until
// it hits a wall, travels too far or runs out of steps, then hands the column
// result downstream with a valid/ack handshake.
// Ports:
//   clk    - single rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - ray_seq_if.slave: start/abort, datapath done flags, distwall,
//            hitwall, col_ack in; phase strobes, col_idx, step_cnt,
//            col_valid, col_timeout, busy, frame_done out
module ray_sequencer #(
  parameter int NUM_COLS  = 640,
  parameter int COL_W     = 10,
  parameter int DIST_W    = 10,
  parameter int MAX_DIST  = 512,
  parameter int MAX_STEPS = 64,
  parameter int STEP_W    = 7
) (
  input logic   clk,
  input logic   rst_n,
  ray_seq_if.slave bus
);

  localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(NUM_COLS - 1);
  localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(MAX_STEPS - 1);
  // One extra bit so a MAX_DIST equal to 2**DIST_W is still representable.
  localparam logic [DIST_W:0]   DIST_LIMIT = (DIST_W + 1)'(MAX_DIST);

  typedef enum logic [2:0] {IDLE, INIT, MULT, LOOP, CEIL, EMIT} state_t;

  state_t            state, state_next;
  logic [COL_W-1:0]  col_idx;
  logic [STEP_W-1:0] step_cnt;
  logic              col_timeout;
  logic              frame_done;

  logic abort_now;
  logic at_step_limit;
  logic too_far;
  logic ray_done;
  logic limit_only;
  logic last_col;

  assign abort_now     = bus.abort && (state != IDLE);
  assign at_step_limit = (step_cnt == LAST_STEP);
  assign too_far       = ({1'b0, bus.distwall} >= DIST_LIMIT);
  assign ray_done      = too_far || bus.hitwall || at_step_limit;
  // Timeout is only reported when nothing else would have ended the ray.
  assign limit_only    = at_step_limit && !too_far && !bus.hitwall;
  assign last_col      = (col_idx == LAST_COL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Abort overrides every other input once a frame is running.
  always_comb begin
    state_next = state;
    if (abort_now) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (bus.start)     state_next = INIT;
        INIT:                       state_next = MULT;
        MULT:    if (bus.mult_done) state_next = LOOP;
        LOOP:    state_next = ray_done ? CEIL : MULT;
        CEIL:    if (bus.ceil_done) state_next = EMIT;
        EMIT:    if (bus.col_ack)   state_next = last_col ? IDLE : INIT;
        default:                    state_next = IDLE;
      endcase
    end
  end

  // Per-ray counters are cleared on the way into INIT so they already read 0
  // during INIT; frame_done is a registered one-cycle pulse seen in the first
  // IDLE cycle after the last column is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_idx     <= '0;
      step_cnt    <= '0;
      col_timeout <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (abort_now) begin
        col_idx     <= '0;
        step_cnt    <= '0;
        col_timeout <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (bus.start) begin
            col_idx     <= '0;
            step_cnt    <= '0;
            col_timeout <= 1'b0;
          end
          LOOP: begin
            if (ray_done) col_timeout <= limit_only;
            else          step_cnt    <= step_cnt + STEP_W'(1);
          end
          EMIT: if (bus.col_ack) begin
            step_cnt    <= '0;
            col_timeout <= 1'b0;
            if (last_col) begin
              col_idx    <= '0;
              frame_done <= 1'b1;
            end else begin
              col_idx <= col_idx + COL_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.init        = (state == INIT);
  assign bus.mult        = (state == MULT);
  assign bus.loop        = (state == LOOP);
  assign bus.ceil_calc   = (state == CEIL);
  assign bus.col_valid   = (state == EMIT);
  assign bus.busy        = (state != IDLE);
  assign bus.col_idx     = col_idx;
  assign bus.step_cnt    = step_cnt;
  assign bus.col_timeout = col_timeout;
  assign bus.frame_done  = frame_done;

endmodule

// File: tb/tb_ray_sequencer.sv
// tb_ray_sequencer: self-checking bench for ray_sequencer with NUM_COLS=4,
// MAX_STEPS=8, MAX_DIST=512. Column-level expectations (loop visits, final
// step count, timeout flag, latency) come from a ray model that walks the
// per-step distance/hit list; a table of hand-derived columns, hand-written
// abort/reset sequences and randomized frames drive the design.
module tb_ray_sequencer;

  localparam int NUM_COLS  = 4;
  localparam int COL_W     = 2;
  localparam int DIST_W    = 10;
  localparam int MAX_DIST  = 512;
  localparam int MAX_STEPS = 8;
  localparam int STEP_W    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ray_seq_if #(.COL_W(COL_W), .STEP_W(STEP_W), .DIST_W(DIST_W)) bus ();

  ray_sequencer #(
    .NUM_COLS(NUM_COLS), .COL_W(COL_W), .DIST_W(DIST_W),
    .MAX_DIST(MAX_DIST), .MAX_STEPS(MAX_STEPS), .STEP_W(STEP_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Per-step ray description for the column currently being cast.
  logic [DIST_W-1:0] rayDist [MAX_STEPS];
  logic              rayHit  [MAX_STEPS];

  typedef struct {
    int           hitAt;
    int           farAt;
    logic [9:0]   nearDist;
    logic [9:0]   farDist;
    int           multWait;
    int           ceilWait;
    int           ackWait;
    int           expSteps;
    logic         expTimeout;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // In any non-IDLE state exactly one of the five phase indicators is high;
  // in IDLE none is.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if ($countones({bus.init, bus.mult, bus.loop, bus.ceil_calc, bus.col_valid})
          != (bus.busy ? 1 : 0)) begin
        errors++;
        $display("[TB] FAIL phase_onehot actual=%b required_busy=%b",
                 {bus.init, bus.mult, bus.loop, bus.ceil_calc, bus.col_valid}, bus.busy);
      end
    end
  end

  // Reference ray model: first step whose distance reaches MAX_DIST or that
  // hits a wall ends the ray; otherwise the last allowed step ends it as a timeout.
  function automatic void predictRay(output int steps, output logic timeout);
    bit found;
    found   = 1'b0;
    steps   = MAX_STEPS - 1;
    timeout = 1'b1;
    for (int k = 0; k < MAX_STEPS; k++) begin
      if (!found && (rayHit[k] || int'(rayDist[k]) >= MAX_DIST)) begin
        found   = 1'b1;
        steps   = k;
        timeout = 1'b0;
      end
    end
  endfunction

  task automatic applyStimulus(input bit startNoise);
    bus.start     = startNoise ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.col_ack   = 1'($urandom_range(0, 1));
    bus.mult_done = 1'($urandom_range(0, 1));
    bus.ceil_done = 1'($urandom_range(0, 1));
    bus.distwall  = DIST_W'($urandom_range(0, 1023));
    bus.hitwall   = 1'($urandom_range(0, 1));
  endtask

  task automatic startFrame();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checkOutput("frame_start_busy", bus.busy, 1);
  endtask

  // Drives one column from INIT up to EMIT (or up to CEIL when stopInCeil).
  task automatic runToEmit(input int multWait, input int ceilWait, input int expSteps,
                           input logic expTimeout, input int expIdx, input bit stopInCeil);
    int loops, cycles, multCnt, ceilCnt;
    loops = 0; cycles = 0; multCnt = 0; ceilCnt = 0;
    checkOutput("init_strobe", bus.init, 1);
    checkOutput("init_col_idx", bus.col_idx, expIdx);
    checkOutput("init_step_cnt", bus.step_cnt, 0);
    checkOutput("init_timeout", bus.col_timeout, 0);
    while (!bus.col_valid && !(stopInCeil && bus.ceil_calc) && cycles < 500) begin
      applyStimulus(1'b1);
      if (bus.mult) begin
        bus.mult_done = (multCnt >= multWait);
        multCnt++;
      end else begin
        multCnt = 0;
      end
      if (bus.ceil_calc) begin
        bus.ceil_done = (ceilCnt >= ceilWait);
        ceilCnt++;
      end
      if (bus.loop) begin
        if (loops < MAX_STEPS) begin
          bus.distwall = rayDist[loops];
          bus.hitwall  = rayHit[loops];
        end
        loops++;
      end
      tick();
      cycles++;
    end
    checkOutput("phase_reached", (cycles < 500) ? 1 : 0, 1);
    checkOutput("loop_visits", loops, expSteps + 1);
    checkOutput("step_cnt", bus.step_cnt, expSteps);
    checkOutput("col_idx", bus.col_idx, expIdx);
    if (!stopInCeil) begin
      checkOutput("emit_latency", cycles, 1 + (expSteps + 1) * (multWait + 2) + ceilWait + 1);
      checkOutput("emit_timeout", bus.col_timeout, expTimeout);
    end
  endtask

  // Holds EMIT for ackWait cycles, then acknowledges.
  task automatic ackPhase(input int ackWait, input int expSteps, input logic expTimeout,
                          input int expIdx, input bit lastCol);
    for (int i = 0; i < ackWait; i++) begin
      applyStimulus(1'b1);
      bus.col_ack = 1'b0;
      tick();
      checkOutput("stall_valid", bus.col_valid, 1);
      checkOutput("stall_col_idx", bus.col_idx, expIdx);
      checkOutput("stall_step_cnt", bus.step_cnt, expSteps);
      checkOutput("stall_timeout", bus.col_timeout, expTimeout);
    end
    applyStimulus(1'b0);
    bus.col_ack = 1'b1;
    tick();
    bus.col_ack = 1'b0;
    checkOutput("ack_frame_done", bus.frame_done, lastCol ? 1 : 0);
    checkOutput("ack_busy", bus.busy, lastCol ? 0 : 1);
    checkOutput("ack_next_init", bus.init, lastCol ? 0 : 1);
    if (lastCol) begin
      tick();
      checkOutput("frame_done_single", bus.frame_done, 0);
      checkOutput("idle_after_frame", bus.busy, 0);
    end
  endtask

  task automatic runColumn(input int multWait, input int ceilWait, input int ackWait,
                           input int expSteps, input logic expTimeout, input int expIdx);
    runToEmit(multWait, ceilWait, expSteps, expTimeout, expIdx, 1'b0);
    ackPhase(ackWait, expSteps, expTimeout, expIdx, expIdx == NUM_COLS - 1);
  endtask

  task automatic fillRay(input int hitAt, input int farAt, input logic [9:0] nearDist,
                         input logic [9:0] farDist);
    for (int k = 0; k < MAX_STEPS; k++) begin
      rayHit[k]  = (k >= hitAt);
      rayDist[k] = (k >= farAt) ? farDist : nearDist;
    end
  endtask

  task automatic checkAllZero(input string name);
    checkOutput(name, {22'd0, bus.init, bus.mult, bus.loop, bus.ceil_calc, bus.col_idx,
                       bus.step_cnt, bus.col_valid, bus.col_timeout, bus.busy, bus.frame_done}, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int steps;
    logic tmo;

    vecs[0] = '{0, 8, 10'd0,   10'd0,    0, 0, 0,  0, 1'b0};
    vecs[1] = '{8, 8, 10'd100, 10'd0,    0, 0, 0,  7, 1'b1};
    vecs[2] = '{8, 0, 10'd0,   10'd600,  0, 0, 0,  0, 1'b0};
    vecs[3] = '{8, 8, 10'd511, 10'd0,    2, 1, 3,  7, 1'b1};
    vecs[4] = '{8, 2, 10'd100, 10'd512,  0, 0, 1,  2, 1'b0};
    vecs[5] = '{7, 8, 10'd100, 10'd0,    1, 0, 0,  7, 1'b0};
    vecs[6] = '{3, 8, 10'd100, 10'd0,    1, 3, 10, 3, 1'b0};
    vecs[7] = '{8, 7, 10'd100, 10'd1023, 0, 2, 2,  7, 1'b0};

    bus.start = 1'b0; bus.abort = 1'b0; bus.mult_done = 1'b0; bus.ceil_done = 1'b0;
    bus.col_ack = 1'b0; bus.distwall = '0; bus.hitwall = 1'b0;

    #2;
    checkAllZero("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("idle_no_start", bus.busy, 0);

    $display("[TB] table-driven columns");
    for (int v = 0; v < 8; v++) begin
      if (v % NUM_COLS == 0) startFrame();
      fillRay(vecs[v].hitAt, vecs[v].farAt, vecs[v].nearDist, vecs[v].farDist);
      runColumn(vecs[v].multWait, vecs[v].ceilWait, vecs[v].ackWait,
                vecs[v].expSteps, vecs[v].expTimeout, v % NUM_COLS);
    end

    $display("[TB] abort in MULT of column 2");
    startFrame();
    fillRay(0, 8, 10'd0, 10'd0);
    runColumn(0, 0, 0, 0, 1'b0, 0);
    runColumn(1, 1, 1, 0, 1'b0, 1);
    bus.start = 1'b1;
    bus.mult_done = 1'b0;
    tick();
    checkOutput("start_ignored_busy_mult", bus.mult, 1);
    checkOutput("start_ignored_col_idx", bus.col_idx, 2);
    bus.abort = 1'b1; bus.mult_done = 1'b1; bus.ceil_done = 1'b1; bus.col_ack = 1'b1;
    tick();
    bus.abort = 1'b0; bus.start = 1'b0; bus.mult_done = 1'b0; bus.ceil_done = 1'b0;
    bus.col_ack = 1'b0;
    checkOutput("abort_busy", bus.busy, 0);
    checkOutput("abort_col_idx", bus.col_idx, 0);
    checkOutput("abort_frame_done", bus.frame_done, 0);
    tick();
    checkOutput("abort_no_frame_done", bus.frame_done, 0);
    checkOutput("abort_stays_idle", bus.busy, 0);

    $display("[TB] abort in EMIT of a timed-out column");
    startFrame();
    runColumn(0, 0, 0, 0, 1'b0, 0);
    fillRay(8, 8, 10'd100, 10'd0);
    runToEmit(0, 0, 7, 1'b1, 1, 1'b0);
    bus.abort = 1'b1; bus.col_ack = 1'b0; bus.start = 1'b0;
    tick();
    bus.abort = 1'b0;
    checkAllZero("abort_emit_outputs");

    $display("[TB] reset during CEIL");
    startFrame();
    fillRay(0, 8, 10'd0, 10'd0);
    runColumn(0, 0, 0, 0, 1'b0, 0);
    fillRay(2, 8, 10'd50, 10'd0);
    runToEmit(0, 0, 2, 1'b0, 1, 1'b1);
    checkOutput("in_ceil", bus.ceil_calc, 1);
    bus.ceil_done = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_reset_outputs");
    bus.start = 1'b1;
    tick();
    checkAllZero("reset_held_outputs");
    #2;
    rst_n = 1'b1;
    bus.start = 1'b0;
    tick();
    checkOutput("post_reset_idle", bus.busy, 0);
    tick();
    checkOutput("post_reset_waits", bus.busy, 0);
    startFrame();
    fillRay(0, 8, 10'd0, 10'd0);
    runColumn(0, 0, 0, 0, 1'b0, 0);

    $display("[TB] randomized frames");
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    for (int f = 0; f < 4; f++) begin
      startFrame();
      for (int c = 0; c < NUM_COLS; c++) begin
        for (int k = 0; k < MAX_STEPS; k++) begin
          rayHit[k]  = ($urandom_range(0, 9) == 0);
          rayDist[k] = ($urandom_range(0, 7) == 0) ? DIST_W'($urandom_range(512, 1023))
                                                   : DIST_W'($urandom_range(0, 511));
        end
        predictRay(steps, tmo);
        runColumn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  steps, tmo, c);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ray_sequencer.md
RAY_SEQUENCER -- requirements
Module: ray_sequencer

Interface
REQ-001 Parameter NUM_COLS, default 640: columns (rays) cast per frame; SHALL be >= 2.
REQ-002 Parameter COL_W, default 10: column index width; SHALL satisfy 2**COL_W >= NUM_COLS.
REQ-003 Parameter DIST_W, default 10: width of distwall.
REQ-004 Parameter MAX_DIST, default 512: distance at or beyond which a ray terminates.
REQ-005 Parameter MAX_STEPS, default 64: step limit per ray; STEP_W, default 7, SHALL satisfy 2**STEP_W > MAX_STEPS.
REQ-006 Clk  in  1  single clock; all state updates on rising edge.
REQ-007 Reset_n  in  1  asynchronous active-low reset.
REQ-008 start  in  1  frame start request; sampled only in IDLE.
REQ-009 abort  in  1  synchronous frame abort.
REQ-010 mult_done  in  1  datapath multiply step complete.
REQ-011 distwall  in  DIST_W  current ray distance, unsigned.
REQ-012 hitwall  in  1  current ray has hit a wall.
REQ-013 ceil_done  in  1  ceiling/height computation complete.
REQ-014 col_ack  in  1  downstream accepted column result.
REQ-015 init, mult, loop, ceil_calc  out  1 each  datapath phase strobes.
REQ-016 col_idx  out  COL_W  current column index.
REQ-017 step_cnt  out  STEP_W  steps taken on current ray.
REQ-018 col_valid  out  1  column result ready; col_timeout  out  1  ray ended by step limit.
REQ-019 busy  out  1  frame in progress; frame_done  out  1  one-cycle end-of-frame pulse.

Function
REQ-020 States SHALL be IDLE, INIT, MULT, LOOP, CEIL, EMIT; all outputs registered or decoded from registered state only.
REQ-021 Strobes: init=1 only in INIT, mult only in MULT, loop only in LOOP, ceil_calc only in CEIL; at most one strobe high per cycle.
REQ-022 IDLE: start=1 -> INIT next cycle, col_idx cleared to 0; otherwise stay; start outside IDLE SHALL be ignored.
REQ-023 INIT: exactly one cycle; step_cnt cleared to 0; -> MULT.
REQ-024 MULT: stay until mult_done=1, then -> LOOP.
REQ-025 LOOP: one cycle; if distwall >= MAX_DIST or hitwall=1 or step_cnt == MAX_STEPS-1 -> CEIL, else step_cnt+1 and -> MULT.
REQ-026 col_timeout SHALL be set on LOOP exit when step limit was the only termination cause, cleared on INIT; held stable through EMIT.
REQ-027 CEIL: stay until ceil_done=1, then -> EMIT.
REQ-028 EMIT: col_valid=1, col_idx/step_cnt/col_timeout stable until col_ack=1 (valid/ack handshake, no drop).
REQ-029 EMIT with col_ack, col_idx < NUM_COLS-1: col_idx+1, -> INIT.
REQ-030 EMIT with col_ack, col_idx == NUM_COLS-1: -> IDLE, col_idx wraps to 0, frame_done=1 for exactly that transition cycle.
REQ-031 busy=1 in every state except IDLE.
REQ-032 abort=1 in any non-IDLE state: -> IDLE next cycle, col_idx and step_cnt to 0, col_timeout 0, no frame_done; abort has priority over all other inputs.
REQ-033 Inputs mult_done, ceil_done, col_ack SHALL be ignored in states that do not wait on them.
REQ-034 Distance comparison unsigned, full DIST_W width; no arithmetic overflow permitted on step_cnt or col_idx.

Reset
REQ-035 Reset_n=0 SHALL immediately force IDLE, all outputs 0, col_idx=0, step_cnt=0, independent of Clk.
REQ-036 Reset mid-frame SHALL discard frame; after release block waits for a new start.

Verification (NUM_COLS=4, MAX_STEPS=8, MAX_DIST=512)
REQ-037 start pulse, mult_done/ceil_done/col_ack tied 1, hitwall=1 -> per column INIT,MULT,LOOP,CEIL,EMIT (5 cycles); 4 col_valid with col_idx 0..3; frame_done single pulse after col 3; busy low next cycle.
REQ-038 hitwall=0, distwall=100 -> 8 LOOP visits, step_cnt=7 at EMIT, col_timeout=1; next column with distwall=600 -> exit after 1 LOOP, col_timeout=0.
REQ-039 col_ack held 0 for 10 cycles in EMIT -> col_valid and col_idx stable 10 cycles, state unchanged; ack -> advance.
REQ-040 abort asserted in MULT of column 2 -> IDLE next cycle, busy=0, col_idx=0, no frame_done; start while busy mid-frame ignored.
REQ-041 Reset_n low between clock edges during CEIL -> outputs 0 immediately; after release, IDLE until start.
